oflow_prev_frame_line_reader: RTL and testbench

- Producer side of the buffer-to-score-calc interface.
- Stores the previous-frame feature lines (one per tracked object).
- On each start, streams them as pairs on two lanes; each pair feeds both similarity-metric PEs for one current object.
- Advances on control_for_read_new_line and signals end-of-frame with done_read; an unused lane 1 is zero-filled, so its ID field reads 0 = invalid.

---
 rtl/oflow_reader_pkg.sv | 25 ++
 rtl/oflow_prev_frame_line_mem.sv | 29 ++
 rtl/oflow_prev_frame_line_reader.sv | 149 ++++++++++++++
 tb/tb_oflow_prev_frame_line_reader.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oflow_reader_pkg.sv
// Shared types and constants for the previous-frame line reader.
// Falls back to local feature widths when the project define files are not in the compile.
`ifndef DATA_TO_PE_WIDTH
`define DATA_TO_PE_WIDTH 48
`endif
`ifndef ID_LEN
`define ID_LEN 8
`endif

package oflow_reader_pkg;

  localparam int unsigned LINE_W       = `DATA_TO_PE_WIDTH;
  localparam int unsigned ID_W         = `ID_LEN;
  localparam int unsigned ID_FIELD_LSB = 0;

  localparam logic [LINE_W-1:0] ZERO_LINE = '0;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    PRESENT,
    DONE
  } reader_state_e;

endpackage

// File: rtl/oflow_prev_frame_line_mem.sv
// DEPTH x DATA_WIDTH register array: one synchronous write port, two combinational read ports.
// Contents are intentionally not reset.
module oflow_prev_frame_line_mem #(
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned DATA_WIDTH = 48,
  parameter int unsigned ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_wr_en,
  input  logic [ADDR_W-1:0]     i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic [ADDR_W-1:0]     i_rd_addr0,
  input  logic [ADDR_W-1:0]     i_rd_addr1,
  output logic [DATA_WIDTH-1:0] o_rd_data0,
  output logic [DATA_WIDTH-1:0] o_rd_data1
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data0 = r_mem[i_rd_addr0];
  assign o_rd_data1 = r_mem[i_rd_addr1];

endmodule

// File: rtl/oflow_prev_frame_line_reader.sv
// Streams stored previous-frame feature lines as pairs on two lanes to the similarity PEs.
// Optional OFLOW_PREV_FRAME_READER_LINE_CNT_EN adds line_idx / lines_served monitor outputs.
module oflow_prev_frame_line_reader
  import oflow_reader_pkg::*;
#(
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned DATA_WIDTH = LINE_W,
  parameter int unsigned ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset_N,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_W:0]       num_of_objects,
  input  logic                  start_read,
  input  logic                  control_for_read_new_line,
  output logic [DATA_WIDTH-1:0] data_to_similarity_metric_0,
  output logic [DATA_WIDTH-1:0] data_to_similarity_metric_1,
  output logic                  done_read,
  output logic                  busy,
`ifdef OFLOW_PREV_FRAME_READER_LINE_CNT_EN
  output logic [ADDR_W-1:0]     line_idx,
  output logic [ADDR_W:0]       lines_served,
`endif
  output logic                  wr_drop_err
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned SUM_W = ADDR_W + 2;

  reader_state_e         r_state;
  logic [ADDR_W-1:0]     r_ptr;
  logic [CNT_W-1:0]      r_num;
  logic [DATA_WIDTH-1:0] r_lane0;
  logic [DATA_WIDTH-1:0] r_lane1;
  logic                  r_wr_drop_err;

  logic                  w_mem_we;
  logic [ADDR_W-1:0]     w_rd_addr0;
  logic [ADDR_W-1:0]     w_rd_addr1;
  logic [DATA_WIDTH-1:0] w_rd_data0;
  logic [DATA_WIDTH-1:0] w_rd_data1;
  logic [CNT_W-1:0]      w_num_sat;
  logic [SUM_W-1:0]      w_pair_base;
  logic                  w_last;
  logic                  w_lane1_valid;
  logic                  w_start;

  assign w_mem_we   = wr_en && (r_state == IDLE);
  assign w_rd_addr0 = ADDR_W'({r_ptr, 1'b0});
  assign w_rd_addr1 = ADDR_W'({r_ptr, 1'b1});

  oflow_prev_frame_line_mem #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_W     (ADDR_W)
  ) u_mem (
    .i_clk      (clk),
    .i_wr_en    (w_mem_we),
    .i_wr_addr  (wr_addr),
    .i_wr_data  (wr_data),
    .i_rd_addr0 (w_rd_addr0),
    .i_rd_addr1 (w_rd_addr1),
    .o_rd_data0 (w_rd_data0),
    .o_rd_data1 (w_rd_data1)
  );

  // The count port is one bit wider than needed for DEPTH, so clamp anything larger.
  assign w_num_sat     = (num_of_objects > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : num_of_objects;
  assign w_pair_base   = {1'b0, r_ptr, 1'b0};
  assign w_last        = (w_pair_base + SUM_W'(2)) >= {1'b0, r_num};
  assign w_lane1_valid = (w_pair_base + SUM_W'(1)) < {1'b0, r_num};
  assign w_start       = start_read && ((r_state == IDLE) || (r_state == DONE));

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      r_state       <= IDLE;
      r_ptr         <= '0;
      r_num         <= '0;
      r_lane0       <= ZERO_LINE;
      r_lane1       <= ZERO_LINE;
      r_wr_drop_err <= 1'b0;
    end else begin
      if (wr_en && (r_state != IDLE)) begin
        r_wr_drop_err <= 1'b1;
      end
      unique case (r_state)
        IDLE, DONE: begin
          r_lane0 <= ZERO_LINE;
          r_lane1 <= ZERO_LINE;
          if (start_read) begin
            r_num   <= w_num_sat;
            r_ptr   <= '0;
            r_state <= (w_num_sat == '0) ? DONE : FETCH;
          end else begin
            r_state <= IDLE;
          end
        end
        FETCH: begin
          r_lane0 <= w_rd_data0;
          r_lane1 <= w_lane1_valid ? w_rd_data1 : ZERO_LINE;
          r_state <= PRESENT;
        end
        PRESENT: begin
          if (control_for_read_new_line) begin
            if (w_last) begin
              r_lane0 <= ZERO_LINE;
              r_lane1 <= ZERO_LINE;
              r_state <= DONE;
            end else begin
              r_ptr   <= r_ptr + ADDR_W'(1);
              r_state <= FETCH;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign data_to_similarity_metric_0 = r_lane0;
  assign data_to_similarity_metric_1 = r_lane1;
  assign done_read   = (r_state == DONE) || ((r_state == PRESENT) && w_last);
  assign busy        = (r_state != IDLE);
  assign wr_drop_err = r_wr_drop_err;

`ifdef OFLOW_PREV_FRAME_READER_LINE_CNT_EN
  logic [CNT_W-1:0] r_lines_served;

  // A pair counts as handed over once it has been loaded onto the lanes.
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      r_lines_served <= '0;
    end else if (w_start) begin
      r_lines_served <= '0;
    end else if ((r_state == FETCH) && (r_lines_served < CNT_W'(DEPTH / 2))) begin
      r_lines_served <= r_lines_served + CNT_W'(1);
    end
  end

  assign line_idx     = ((r_state == FETCH) || (r_state == PRESENT)) ? r_ptr : '0;
  assign lines_served = r_lines_served;
`else
  logic w_unused_start;
  assign w_unused_start = w_start;
`endif

endmodule

// File: tb/tb_oflow_prev_frame_line_reader.sv
// Directed self-checking bench for oflow_prev_frame_line_reader (default build).
module tb_oflow_prev_frame_line_reader;
  import oflow_reader_pkg::*;

  localparam int unsigned DEPTH  = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DW     = LINE_W;

  logic              clk;
  logic              reset_N;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DW-1:0]     wr_data;
  logic [ADDR_W:0]   num_of_objects;
  logic              start_read;
  logic              req;
  logic [DW-1:0]     lane0;
  logic [DW-1:0]     lane1;
  logic              done_read;
  logic              busy;
  logic              wr_drop_err;
`ifdef OFLOW_PREV_FRAME_READER_LINE_CNT_EN
  logic [ADDR_W-1:0] line_idx;
  logic [ADDR_W:0]   lines_served;
`endif

  int checks;
  int errors;

  oflow_prev_frame_line_reader #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DW),
    .ADDR_W     (ADDR_W)
  ) dut (
    .clk                         (clk),
    .reset_N                     (reset_N),
    .wr_en                       (wr_en),
    .wr_addr                     (wr_addr),
    .wr_data                     (wr_data),
    .num_of_objects              (num_of_objects),
    .start_read                  (start_read),
    .control_for_read_new_line   (req),
    .data_to_similarity_metric_0 (lane0),
    .data_to_similarity_metric_1 (lane1),
    .done_read                   (done_read),
    .busy                        (busy),
`ifdef OFLOW_PREV_FRAME_READER_LINE_CNT_EN
    .line_idx                    (line_idx),
    .lines_served                (lines_served),
`endif
    .wr_drop_err                 (wr_drop_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [DW-1:0] mk_line(input int id);
    logic [DW-1:0] l;
    l = '0;
    l[DW-1:DW-8] = 8'h5A;
    l[ID_W+31:ID_W] = 32'(id) * 32'h0101_0101;
    l[ID_FIELD_LSB +: ID_W] = ID_W'(id);
    return l;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int addr, input int id);
    wr_en   = 1'b1;
    wr_addr = ADDR_W'(addr);
    wr_data = mk_line(id);
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic start(input int n);
    num_of_objects = (ADDR_W + 1)'(n);
    start_read     = 1'b1;
    tick();
    start_read     = 1'b0;
  endtask

  task automatic request();
    req = 1'b1;
    tick();
    req = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (lane0 !== '0 || lane1 !== '0) begin
      errors++;
      $display("FAIL reset_lanes got %h/%h exp 0/0", lane0, lane1);
    end
    checks++;
    if ({done_read, busy, wr_drop_err} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got %b exp 000", {done_read, busy, wr_drop_err});
    end
  endtask

  task automatic test_odd_n();
    for (int i = 0; i < 5; i++) load(i, i + 1);
    start(5);
    checks++;
    if ({busy, done_read} !== 2'b10) begin
      errors++;
      $display("FAIL odd_fetch_flags got %b exp 10", {busy, done_read});
    end
    tick();
    checks++;
    if (lane0 !== mk_line(1) || lane1 !== mk_line(2) || done_read !== 1'b0) begin
      errors++;
      $display("FAIL odd_pair0 got %h/%h d%b exp id1/id2 d0", lane0, lane1, done_read);
    end
    request();
    checks++;
    if (lane0 !== mk_line(1) || lane1 !== mk_line(2)) begin
      errors++;
      $display("FAIL odd_hold_in_fetch got %h/%h exp id1/id2", lane0, lane1);
    end
    tick();
    checks++;
    if (lane0 !== mk_line(3) || lane1 !== mk_line(4) || done_read !== 1'b0) begin
      errors++;
      $display("FAIL odd_pair1 got %h/%h d%b exp id3/id4 d0", lane0, lane1, done_read);
    end
    // Request held through FETCH must not skip a pair.
    req = 1'b1;
    tick();
    tick();
    req = 1'b0;
    checks++;
    if (lane0 !== mk_line(5) || lane1 !== '0 || done_read !== 1'b1) begin
      errors++;
      $display("FAIL odd_pair2 got %h/%h d%b exp id5/0 d1", lane0, lane1, done_read);
    end
    request();
    checks++;
    if (lane0 !== '0 || lane1 !== '0 || {done_read, busy} !== 2'b11) begin
      errors++;
      $display("FAIL odd_done got %h/%h %b exp 0/0 11", lane0, lane1, {done_read, busy});
    end
    tick();
    checks++;
    if ({done_read, busy} !== 2'b00) begin
      errors++;
      $display("FAIL odd_idle got %b exp 00", {done_read, busy});
    end
  endtask

  task automatic test_even_n();
    for (int i = 0; i < 4; i++) load(i, 10 + i);
    start(4);
    tick();
    checks++;
    if (lane0 !== mk_line(10) || lane1 !== mk_line(11) || done_read !== 1'b0) begin
      errors++;
      $display("FAIL even_pair0 got %h/%h d%b exp id10/id11 d0", lane0, lane1, done_read);
    end
    request();
    tick();
    checks++;
    if (lane0 !== mk_line(12) || lane1 !== mk_line(13) || done_read !== 1'b1) begin
      errors++;
      $display("FAIL even_pair1 got %h/%h d%b exp id12/id13 d1", lane0, lane1, done_read);
    end
    request();
    checks++;
    if (lane0 !== '0 || lane1 !== '0 || {done_read, busy} !== 2'b11) begin
      errors++;
      $display("FAIL even_done got %h/%h %b exp 0/0 11", lane0, lane1, {done_read, busy});
    end
    tick();
    checks++;
    if (lane0 !== '0 || lane1 !== '0 || {done_read, busy} !== 2'b00) begin
      errors++;
      $display("FAIL even_idle got %h/%h %b exp 0/0 00", lane0, lane1, {done_read, busy});
    end
  endtask

  task automatic test_n_zero();
    start(0);
    checks++;
    if (lane0 !== '0 || lane1 !== '0 || {done_read, busy} !== 2'b11) begin
      errors++;
      $display("FAIL nzero_done got %h/%h %b exp 0/0 11", lane0, lane1, {done_read, busy});
    end
    tick();
    checks++;
    if (lane0 !== '0 || lane1 !== '0 || {done_read, busy} !== 2'b00) begin
      errors++;
      $display("FAIL nzero_idle got %h/%h %b exp 0/0 00", lane0, lane1, {done_read, busy});
    end
  endtask

  task automatic test_wr_drop();
    start(4);
    tick();
    load(3, 99);
    checks++;
    if (wr_drop_err !== 1'b1 || lane0 !== mk_line(10) || lane1 !== mk_line(11)) begin
      errors++;
      $display("FAIL drop_flag got err%b %h/%h exp err1 id10/id11", wr_drop_err, lane0, lane1);
    end
    request();
    tick();
    checks++;
    if (lane1 !== mk_line(13)) begin
      errors++;
      $display("FAIL drop_mem3 got %h exp %h", lane1, mk_line(13));
    end
    request();
    tick();
    checks++;
    if (wr_drop_err !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL drop_sticky got err%b busy%b exp err1 busy0", wr_drop_err, busy);
    end
  endtask

  task automatic test_reset_mid();
    start(4);
    tick();
    #2 reset_N = 1'b0;
    #1;
    checks++;
    if (lane0 !== '0 || lane1 !== '0 || {done_read, busy, wr_drop_err} !== 3'b000) begin
      errors++;
      $display("FAIL midrst_async got %h/%h %b exp 0/0 000", lane0, lane1,
               {done_read, busy, wr_drop_err});
    end
    @(negedge clk);
    reset_N = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_idle got busy%b exp busy0", busy);
    end
    start(4);
    tick();
    checks++;
    if (lane0 !== mk_line(10) || lane1 !== mk_line(11) || done_read !== 1'b0) begin
      errors++;
      $display("FAIL midrst_pair0 got %h/%h d%b exp id10/id11 d0", lane0, lane1, done_read);
    end
    request();
    tick();
    request();
    tick();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) load(i, i + 1);
    start(3);
    tick();
    for (int pass = 0; pass < 2; pass++) begin
      checks++;
      if (lane0 !== mk_line(1) || lane1 !== mk_line(2) || done_read !== 1'b0) begin
        errors++;
        $display("FAIL b2b_pair0_pass%0d got %h/%h d%b exp id1/id2 d0", pass, lane0, lane1,
                 done_read);
      end
      request();
      tick();
      checks++;
      if (lane0 !== mk_line(3) || lane1 !== '0 || done_read !== 1'b1) begin
        errors++;
        $display("FAIL b2b_pair1_pass%0d got %h/%h d%b exp id3/0 d1", pass, lane0, lane1,
                 done_read);
      end
      request();
      if (pass == 0) begin
        start(3);
        tick();
      end
    end
    tick();
    checks++;
    if ({done_read, busy} !== 2'b00) begin
      errors++;
      $display("FAIL b2b_idle got %b exp 00", {done_read, busy});
    end
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    reset_N        = 1'b1;
    wr_en          = 1'b0;
    wr_addr        = '0;
    wr_data        = '0;
    num_of_objects = '0;
    start_read     = 1'b0;
    req            = 1'b0;
    #2 reset_N = 1'b0;
    #1;
    test_reset();
    @(negedge clk);
    reset_N = 1'b1;
    tick();
    test_odd_n();
    test_even_n();
    test_n_zero();
    test_wr_drop();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
